// File: rtl/controlador_contador_if.sv
// Control/status bundle between a host and the controlador_contador counter FSM.
// Latency: n/a (wires only). Backpressure: none; commands are plain levels/pulses.
// Ports: master = host (drives start/pausa/parar/modo/limite, reads status);
//        slave  = controller (the reverse). vueltas exists only with CONTROLADOR_VUELTAS_EN.
interface controlador_contador_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             pausa;
    logic             parar;
    logic             modo;
    logic [WIDTH-1:0] limite;
    logic [WIDTH-1:0] cuenta;
    logic             ocupado;
    logic             fin;
    logic [1:0]       estado;
`ifdef CONTROLADOR_VUELTAS_EN
    logic [7:0]       vueltas;
`endif

    modport master (
`ifdef CONTROLADOR_VUELTAS_EN
        input  vueltas,
`endif
        output start, pausa, parar, modo, limite,
        input  cuenta, ocupado, fin, estado
    );

    modport slave (
`ifdef CONTROLADOR_VUELTAS_EN
        output vueltas,
`endif
        input  start, pausa, parar, modo, limite,
        output cuenta, ocupado, fin, estado
    );
endinterface

// File: rtl/controlador_contador.sv
// FSM sequencing a modulo-(limit+1) up-counter with start/pause/stop, one-shot or continuous mode.
// Latency: start seen at edge k -> cuenta=0 after k; one-shot limit L -> fin pulse after edge k+L+1.
// Backpressure: none; parar > pausa > start priority, start honoured only when idle.
// Ports: clk, rst (async, active-high); bus (controlador_contador_if.slave):
//   start/pausa/parar/modo/limite in, cuenta/ocupado/fin/estado out.
// Optional macro CONTROLADOR_VUELTAS_EN adds bus.vueltas, a saturating 8-bit count of fin pulses.
module controlador_contador #(
    parameter int             WIDTH      = 4,
    parameter logic [WIDTH-1:0] LIMITE_DEF = WIDTH'(10)
) (
    input  logic                   clk,
    input  logic                   rst,
    controlador_contador_if.slave  bus
);
    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2,
        FIN      = 2'd3
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] cuenta_q, cuenta_d;
    logic [WIDTH-1:0] lim_q,    lim_d;
    logic             modo_q,   modo_d;
    logic             fin_q,    fin_d;
`ifdef CONTROLADOR_VUELTAS_EN
    logic [7:0]       vueltas_q, vueltas_d;
`endif

    // All Q registers live here; the next values come purely from Q state and inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= REPOSO;
            cuenta_q  <= '0;
            lim_q     <= LIMITE_DEF;
            modo_q    <= 1'b0;
            fin_q     <= 1'b0;
`ifdef CONTROLADOR_VUELTAS_EN
            vueltas_q <= 8'd0;
`endif
        end else begin
            estado_q  <= estado_d;
            cuenta_q  <= cuenta_d;
            lim_q     <= lim_d;
            modo_q    <= modo_d;
            fin_q     <= fin_d;
`ifdef CONTROLADOR_VUELTAS_EN
            vueltas_q <= vueltas_d;
`endif
        end
    end

    // Next-state / next-count logic.
    always_comb begin
        estado_d  = estado_q;
        cuenta_d  = cuenta_q;
        lim_d     = lim_q;
        modo_d    = modo_q;
        fin_d     = 1'b0;       // fin is a single-cycle pulse unless re-armed below
`ifdef CONTROLADOR_VUELTAS_EN
        vueltas_d = vueltas_q;
`endif
        if (bus.parar) begin
            // Stop wins over everything, from any state.
            estado_d  = REPOSO;
            cuenta_d  = '0;
`ifdef CONTROLADOR_VUELTAS_EN
            vueltas_d = 8'd0;
`endif
        end else begin
            unique case (estado_q)
                REPOSO: begin
                    if (bus.start) begin
                        estado_d  = CONTANDO;
                        lim_d     = bus.limite;
                        modo_d    = bus.modo;
                        cuenta_d  = '0;
`ifdef CONTROLADOR_VUELTAS_EN
                        vueltas_d = 8'd0;
`endif
                    end
                end
                CONTANDO: begin
                    if (bus.pausa) begin
                        estado_d = PAUSADO;
                    end else if (cuenta_q == lim_q) begin
                        fin_d = 1'b1;
`ifdef CONTROLADOR_VUELTAS_EN
                        if (vueltas_q != 8'hFF) vueltas_d = vueltas_q + 8'd1;
`endif
                        if (modo_q) cuenta_d = '0;
                        else        estado_d = FIN;   // one-shot holds the limit value
                    end else begin
                        // Cannot overflow: the wrap happens at lim_q <= 2^WIDTH-1.
                        cuenta_d = cuenta_q + 1'b1;
                    end
                end
                PAUSADO: begin
                    // Resume costs one edge; the next increment happens one edge later.
                    if (!bus.pausa) estado_d = CONTANDO;
                end
                FIN: begin
                    estado_d = REPOSO;
                end
                default: begin
                    estado_d = REPOSO;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        bus.cuenta  = cuenta_q;
        bus.fin     = fin_q;
        bus.estado  = estado_q;
        bus.ocupado = (estado_q == CONTANDO) || (estado_q == PAUSADO);
`ifdef CONTROLADOR_VUELTAS_EN
        bus.vueltas = vueltas_q;
`endif
    end
endmodule
